// File: rtl/edabk_receiver.sv
// ---------------------------------------------------------------------------
// edabk_receiver
//
// Oversampling asynchronous serial receiver. A frame is a low start bit,
// DATA_WIDTH data bits sent LSB first, an optional odd-parity bit and one
// high stop bit. Every bit lasts CLK_DIV periods of bclk. The start bit is
// re-checked at its midpoint. Each later bit is sampled one full bit period
// after the previous sample, which keeps every sample near the bit centre.
//
// Parameters
//   CLK_DIV      bclk periods per serial bit
//   DATA_WIDTH   data bits per frame (2 or more)
//   COUNT_WIDTH  width of the sample counter
//
// Ports
//   bclk        in   baud clock, the only clock
//   reset       in   synchronous, active-high reset
//   rx_in       in   serial line, idle high
//   parity      in   1 = frame carries an odd-parity bit (latched at start)
//   rx_data     out  last received data word
//   rx_valid    out  one-cycle pulse when a frame completes
//   parity_err  out  parity check result of the last frame
//   frame_err   out  stop-bit error of the last frame
//   busy        out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
`ifndef CFG_CLK_DIV
`define CFG_CLK_DIV 16
`endif
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module edabk_receiver #(
    parameter int CLK_DIV     = `CFG_CLK_DIV,
    parameter int DATA_WIDTH  = `CFG_DATA_WIDTH,
    parameter int COUNT_WIDTH = $clog2(CLK_DIV)
) (
    input  logic                  bclk,
    input  logic                  reset,
    input  logic                  rx_in,
    input  logic                  parity,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int HALF      = CLK_DIV / 2;
    localparam int IDX_WIDTH = $clog2(DATA_WIDTH + 1);

    localparam logic [COUNT_WIDTH-1:0] CNT_HALF_LAST = COUNT_WIDTH'(HALF - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_BIT_LAST  = COUNT_WIDTH'(CLK_DIV - 1);
    localparam logic [IDX_WIDTH-1:0]   IDX_LAST      = IDX_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PAR       = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    state_t                  r_state;
    logic                    r_sync1;
    logic                    r_sync2;
    logic [COUNT_WIDTH-1:0]  r_cnt;
    logic [IDX_WIDTH-1:0]    r_idx;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_pbit;
    logic                    r_p_lat;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic                    r_rx_valid;
    logic                    r_parity_err;
    logic                    r_frame_err;
    logic                    r_busy;

    // Synchronised copy of the serial line.
    logic w_s;
    // Marks the bclk on which a DATA/PAR/STOP bit is sampled.
    logic w_bit_tick;

    assign w_s        = r_sync2;
    assign w_bit_tick = (r_cnt == CNT_BIT_LAST);

    always_ff @(posedge bclk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_pbit       <= 1'b0;
            r_p_lat      <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_sync1    <= rx_in;
            r_sync2    <= r_sync1;
            r_rx_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (!w_s) begin
                        // The parity mode is frozen here for the whole frame.
                        r_state <= ST_START;
                        r_cnt   <= '0;
                        r_p_lat <= parity;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (r_cnt == CNT_HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_s) begin
                            r_state <= ST_DATA;
                            r_idx   <= '0;
                        end else begin
                            // The line went high again before mid-bit, so the
                            // low level was a glitch. Drop it silently.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_bit_tick) begin
                        r_cnt   <= '0;
                        // LSB arrives first, so shift right and fill from the MSB.
                        r_shift <= {w_s, r_shift[DATA_WIDTH-1:1]};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == IDX_LAST) begin
                            r_state <= r_p_lat ? ST_PAR : ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_PAR: begin
                    if (w_bit_tick) begin
                        r_cnt   <= '0;
                        r_pbit  <= w_s;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (w_bit_tick) begin
                        r_cnt        <= '0;
                        r_rx_data    <= r_shift;
                        r_frame_err  <= ~w_s;
                        // Odd parity: data XOR parity bit must be 1.
                        r_parity_err <= r_p_lat & ~(^r_shift ^ r_pbit);
                        r_rx_valid   <= 1'b1;
                        if (w_s) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            // A low stop bit could be a break. Do not treat
                            // that low level as a new start bit.
                            r_state <= ST_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_WAIT_HIGH: begin
                    if (w_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_edabk_receiver.sv
// ---------------------------------------------------------------------------
// tb_edabk_receiver
//
// Directed bench for edabk_receiver with CLK_DIV=16 and DATA_WIDTH=8.
// Frames are driven bit by bit on rx_in. A negedge monitor records each
// rx_valid pulse: the cycle it occurred in and the word it carried.
//
// All latencies are measured from the cycle in which rx_in is driven low.
// That adds the two synchroniser stages to the receiver's own latency:
//   no parity : 2 + 1 + 8 +  9*16 = 155
//   parity    : 2 + 1 + 8 + 10*16 = 171
// ---------------------------------------------------------------------------
module tb_edabk_receiver;

    localparam int CLK_DIV    = 16;
    localparam int DATA_WIDTH = 8;
    localparam int LAT_NOPAR  = 155;
    localparam int LAT_PAR    = 171;

    logic       bclk   = 1'b0;
    logic       reset  = 1'b1;
    logic       rx_in  = 1'b1;
    logic       parity = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    int         cyc             = 0;
    int         pulses          = 0;
    int         hi_cycles       = 0;
    int         last_valid_cyc  = 0;
    int         prev_valid_cyc  = 0;
    logic [7:0] last_data       = 8'h00;
    logic [7:0] prev_data       = 8'h00;
    logic       valid_d         = 1'b0;
    int         frame_start_cyc = 0;
    int         p0;
    int         h0;

    edabk_receiver #(
        .CLK_DIV    (CLK_DIV),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .bclk       (bclk),
        .reset      (reset),
        .rx_in      (rx_in),
        .parity     (parity),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 bclk = ~bclk;

    always @(posedge bclk) cyc <= cyc + 1;

    always @(negedge bclk) begin
        if (rx_valid) begin
            hi_cycles = hi_cycles + 1;
            if (!valid_d) begin
                pulses         = pulses + 1;
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
                prev_data      = last_data;
                last_data      = rx_data;
                $display("rx_valid @cyc %0d data=%02h perr=%0b ferr=%0b",
                         cyc, rx_data, parity_err, frame_err);
            end
        end
        valid_d = rx_valid;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        if (obs !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold_bit(input logic b);
        @(posedge bclk); #1;
        rx_in = b;
        repeat (CLK_DIV - 1) @(posedge bclk);
    endtask

    // Drive a complete frame. The task returns 1 time unit after the last
    // edge of the stop bit. The line is left at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic pb,
                              input logic stop_b, input int stop_len, input logic tog);
        @(posedge bclk); #1;
        rx_in           = 1'b0;
        parity          = par_en;
        frame_start_cyc = cyc;
        repeat (CLK_DIV - 1) @(posedge bclk);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            @(posedge bclk); #1;
            rx_in = d[i];
            if (tog && i == 3) parity = ~parity;
            repeat (CLK_DIV - 1) @(posedge bclk);
        end
        if (par_en) hold_bit(pb);
        @(posedge bclk); #1;
        rx_in = stop_b;
        repeat (stop_len - 1) @(posedge bclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge bclk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge bclk);
        #1;
        check_val("rst_rx_data",    rx_data,    0);
        check_val("rst_rx_valid",   rx_valid,   0);
        check_val("rst_parity_err", parity_err, 0);
        check_val("rst_frame_err",  frame_err,  0);
        check_val("rst_busy",       busy,       0);
        reset = 1'b0;
        idle(5);

        // ---------------- 0xA5, no parity ----------------
        p0 = pulses; h0 = hi_cycles;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, CLK_DIV, 1'b0);
        check_val("a5_pulses",  pulses - p0, 1);
        check_val("a5_width",   hi_cycles - h0, 1);
        check_val("a5_latency", last_valid_cyc - frame_start_cyc, LAT_NOPAR);
        check_val("a5_data",    rx_data, 8'hA5);
        check_val("a5_perr",    parity_err, 0);
        check_val("a5_ferr",    frame_err, 0);
        check_val("a5_busy",    busy, 0);
        idle(5);

        // ---------------- 0x3C, parity, good pbit ----------------
        p0 = pulses;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, CLK_DIV, 1'b0);
        check_val("3c_ok_pulses",  pulses - p0, 1);
        check_val("3c_ok_latency", last_valid_cyc - frame_start_cyc, LAT_PAR);
        check_val("3c_ok_data",    rx_data, 8'h3C);
        check_val("3c_ok_perr",    parity_err, 0);
        idle(5);

        // ---------------- 0x3C, parity, bad pbit ----------------
        p0 = pulses;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, CLK_DIV, 1'b0);
        check_val("3c_bad_pulses", pulses - p0, 1);
        check_val("3c_bad_data",   rx_data, 8'h3C);
        check_val("3c_bad_perr",   parity_err, 1);
        check_val("3c_bad_ferr",   frame_err, 0);
        idle(5);

        // ---------------- glitch: 4 bclks low ----------------
        p0 = pulses;
        @(posedge bclk); #1;
        rx_in = 1'b0;
        repeat (4) @(posedge bclk);
        #1;
        check_val("glitch_busy_hi", busy, 1);
        rx_in = 1'b1;
        idle(20);
        check_val("glitch_pulses",  pulses - p0, 0);
        check_val("glitch_busy_lo", busy, 0);
        check_val("glitch_data",    rx_data, 8'h3C);
        check_val("glitch_perr",    parity_err, 1);

        // ---------------- 0x81 with low stop, line low 40 bclks ----------------
        p0 = pulses;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 40, 1'b0);
        check_val("ferr_pulses",  pulses - p0, 1);
        check_val("ferr_data",    rx_data, 8'h81);
        check_val("ferr_flag",    frame_err, 1);
        check_val("ferr_busy_lo", busy, 1);
        rx_in = 1'b1;
        idle(2);
        check_val("ferr_busy_sync", busy, 1);
        idle(1);
        check_val("ferr_busy_rel", busy, 0);
        idle(10);
        check_val("ferr_no_second", pulses - p0, 1);

        // ---------------- 0x42 clean after the frame error ----------------
        p0 = pulses;
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, CLK_DIV, 1'b0);
        check_val("42_pulses", pulses - p0, 1);
        check_val("42_data",   rx_data, 8'h42);
        check_val("42_ferr",   frame_err, 0);
        check_val("42_perr",   parity_err, 0);
        idle(5);

        // ---------------- back-to-back 0x01, 0xFE ----------------
        p0 = pulses; h0 = hi_cycles;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, CLK_DIV, 1'b0);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b1, CLK_DIV, 1'b0);
        check_val("b2b_pulses", pulses - p0, 2);
        check_val("b2b_width",  hi_cycles - h0, 2);
        check_val("b2b_gap",    last_valid_cyc - prev_valid_cyc, 10 * CLK_DIV);
        check_val("b2b_first",  prev_data, 8'h01);
        check_val("b2b_second", last_data, 8'hFE);
        idle(5);

        // ---------------- parity toggled mid-frame 0 -> 1 ----------------
        p0 = pulses;
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, CLK_DIV, 1'b1);
        check_val("tog01_pulses",  pulses - p0, 1);
        check_val("tog01_latency", last_valid_cyc - frame_start_cyc, LAT_NOPAR);
        check_val("tog01_data",    rx_data, 8'h96);
        check_val("tog01_perr",    parity_err, 0);
        idle(5);

        // ---------------- parity toggled mid-frame 1 -> 0 ----------------
        p0 = pulses;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, CLK_DIV, 1'b1);
        check_val("tog10_pulses",  pulses - p0, 1);
        check_val("tog10_latency", last_valid_cyc - frame_start_cyc, LAT_PAR);
        check_val("tog10_data",    rx_data, 8'h3C);
        check_val("tog10_perr",    parity_err, 1);
        idle(5);

        // ---------------- reset during data bit 3 of 0xFF ----------------
        p0 = pulses;
        parity = 1'b0;
        @(posedge bclk); #1;
        rx_in = 1'b0;
        repeat (CLK_DIV - 1) @(posedge bclk);
        for (int i = 0; i < 3; i++) hold_bit(1'b1);
        @(posedge bclk); #1;
        rx_in = 1'b1;
        repeat (7) @(posedge bclk);
        #1;
        check_val("prerst_busy", busy, 1);
        reset = 1'b1;
        @(posedge bclk); #1;
        check_val("midrst_data",     rx_data, 0);
        check_val("midrst_valid",    rx_valid, 0);
        check_val("midrst_perr",     parity_err, 0);
        check_val("midrst_ferr",     frame_err, 0);
        check_val("midrst_busy",     busy, 0);
        reset = 1'b0;
        idle(8 + 5 * CLK_DIV);
        check_val("midrst_pulses",   pulses - p0, 0);
        check_val("midrst_busy_end", busy, 0);

        // ---------------- 0x5A after reset ----------------
        p0 = pulses;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, CLK_DIV, 1'b0);
        check_val("5a_pulses",  pulses - p0, 1);
        check_val("5a_latency", last_valid_cyc - frame_start_cyc, LAT_NOPAR);
        check_val("5a_data",    rx_data, 8'h5A);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
